// File: rtl/mux_pkg.sv
// Shared encodings for the channel multiplexer family.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Occupancy of the single-entry output register
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set request at or above ptr, wrapping modulo N_CH.
module rr_pick #(
   parameter  int unsigned N_CH  = 8,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   // One extra bit so ptr + offset never overflows before the modulo fold
   logic [SEL_W:0] cand;

   // Scan exactly N_CH candidates starting at ptr; the earliest hit wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cand = {1'b0, ptr} + (SEL_W+1)'(i);
         if (cand >= (SEL_W+1)'(N_CH)) begin
            cand = cand - (SEL_W+1)'(N_CH);
         end
         if (!found && req[cand[SEL_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_rr_nx1.sv
// N:1 multiplexer with manual or round-robin select, valid/ready on every channel,
// and a single-entry registered output.
module mux_rr_nx1
   import mux_pkg::*;
#(
   parameter  int unsigned N_CH  = 8,
   parameter  int unsigned W     = 8,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   // Valid vector padded to the full select range so out-of-range sel reads a zero
   localparam int unsigned N_PAD = 32'd1 << SEL_W;

   out_state_e        state_q, state_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [N_PAD-1:0]  valid_pad_c;
   logic              sel_ok_c;
   logic              load_c;
   logic              rr_found_c;
   logic [SEL_W-1:0]  rr_idx_c;
   logic              grant_c;
   logic [SEL_W-1:0]  grant_idx_c;
   logic [W-1:0]      ch_data_c [N_CH];

   rr_pick #(
      .N_CH (N_CH)
   ) u_rr_pick (
      .req   (in_valid),
      .ptr   (rr_ptr_q),
      .found (rr_found_c),
      .idx   (rr_idx_c)
   );

   // Unpack the flat channel bus
   always_comb begin
      for (int unsigned c = 0; c < N_CH; c++) begin
         ch_data_c[c] = in_data[c*W +: W];
      end
   end

   // Grant selection; the output slot can take a word when empty or draining
   always_comb begin
      valid_pad_c = N_PAD'(in_valid);
      sel_ok_c    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
      load_c      = (state_q == OUT_EMPTY) || out_ready;
      grant_c     = 1'b0;
      grant_idx_c = '0;
      if (rst_n && load_c) begin
         if (mode == MODE_RR) begin
            grant_c     = rr_found_c;
            grant_idx_c = rr_found_c ? rr_idx_c : '0;
         end else if (sel_ok_c && valid_pad_c[sel]) begin
            grant_c     = 1'b1;
            grant_idx_c = sel;
         end
      end
      in_ready = grant_c ? (N_CH'(1) << grant_idx_c) : '0;
   end

   // Output occupancy register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= OUT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Occupancy next state: fill on transfer, empty on drain without refill
   always_comb begin
      state_d = state_q;
      if (grant_c) begin
         state_d = OUT_FULL;
      end else if ((state_q == OUT_FULL) && out_ready) begin
         state_d = OUT_EMPTY;
      end
   end

   // Occupancy output decode
   always_comb begin
      out_valid = (state_q == OUT_FULL);
   end

   // Datapath next state: capture granted word; advance pointer on round-robin transfers only
   always_comb begin
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      rr_ptr_d   = rr_ptr_q;
      if (grant_c) begin
         out_data_d = ch_data_c[grant_idx_c];
         out_ch_d   = grant_idx_c;
         if (mode == MODE_RR) begin
            rr_ptr_d = (grant_idx_c == SEL_W'(N_CH-1)) ? '0 : grant_idx_c + SEL_W'(1);
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q <= '0;
         out_ch_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         out_data_q <= out_data_d;
         out_ch_q   <= out_ch_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign out_data = out_data_q;
   assign out_ch   = out_ch_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed bench for mux_rr_nx1: an 8-channel build plus a 5-channel build for range edges.
module tb_mux_rr_nx1;

   logic        clk;
   logic        rst_n;

   logic        mode;
   logic [2:0]  sel;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        mode5;
   logic [2:0]  sel5;
   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic [7:0]  out_data5;
   logic [2:0]  out_ch5;
   logic        out_valid5;
   logic        out_ready5;

   int checks;
   int failures;

   mux_rr_nx1 #(.N_CH(8), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mux_rr_nx1 #(.N_CH(5), .W(8)) dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode5),
      .sel       (sel5),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .out_data  (out_data5),
      .out_ch    (out_ch5),
      .out_valid (out_valid5),
      .out_ready (out_ready5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          c;
   logic [7:0]  onehot;
   logic [2:0]  skip_seq [4];
   logic [2:0]  rr5_seq [6];

   initial begin
      checks   = 0;
      failures = 0;
      skip_seq = '{3'd2, 3'd7, 3'd2, 3'd7};
      rr5_seq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 3'd0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
      mode5      = 1'b0;
      sel5       = 3'd0;
      in_valid5  = 5'h00;
      out_ready5 = 1'b1;
      for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hB0 + 8'(i);

      // Reset held two cycles with every channel valid
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_ch",    64'(out_ch),    64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);

      // Round-robin fairness from a fresh pointer: 0..7 then 0,1, one word per cycle
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         c = k % 8;
         #1;
         check("rr_in_ready", 64'(in_ready), 64'(8'd1 << c));
         tick();
         check("rr_out_ch",    64'(out_ch),    64'(c));
         check("rr_out_data",  64'(out_data),  64'(8'hA0 + 8'(c)));
         check("rr_out_valid", 64'(out_valid), 64'd1);
      end

      // Skip idle channels and wrap 7 -> 0 (pointer is 2 here)
      in_valid = 8'b1000_0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("skip_out_ch",   64'(out_ch),   64'(skip_seq[k]));
         check("skip_out_data", 64'(out_data), 64'(8'hA0 + 8'(skip_seq[k])));
      end

      // Manual sweep with only the selected channel valid
      mode = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel      = 3'(s);
         onehot   = 8'd1 << s;
         in_valid = onehot;
         #1;
         check("man_in_ready", 64'(in_ready), 64'(onehot));
         tick();
         check("man_out_data", 64'(out_data), 64'(8'hA0 + 8'(s)));
         check("man_out_ch",   64'(out_ch),   64'(s));
      end

      // Selected channel idle: no grant, output drains
      sel      = 3'd3;
      in_valid = 8'hF7;
      #1;
      check("man_idle_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("man_idle_out_valid", 64'(out_valid), 64'd0);

      // Backpressure: hold word from channel 4 for five cycles
      sel      = 3'd4;
      in_valid = 8'h10;
      tick();
      check("bp_load_data", 64'(out_data), 64'hA4);
      out_ready          = 1'b0;
      in_data[4*8 +: 8]  = 8'h55;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         check("bp_out_data",  64'(out_data),  64'hA4);
         check("bp_out_ch",    64'(out_ch),    64'd4);
         check("bp_out_valid", 64'(out_valid), 64'd1);
      end
      // Drain and load in the same cycle
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'h10);
      tick();
      check("bp_release_data",  64'(out_data),  64'h55);
      check("bp_release_valid", 64'(out_valid), 64'd1);
      in_data[4*8 +: 8] = 8'hA4;

      // Pointer retained across manual mode (last round-robin grant was 7)
      mode     = 1'b1;
      in_valid = 8'hFF;
      #1;
      check("ptr_kept_in_ready", 64'(in_ready), 64'h01);
      tick();
      check("ptr_kept_out_ch", 64'(out_ch), 64'd0);

      // Reset while a word is held discards it
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data",  64'(out_data),  64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 8'h00;

      // Five-channel build: out-of-range select never grants or wraps
      mode5     = 1'b0;
      sel5      = 3'd6;
      in_valid5 = 5'h1F;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("n5_sel6_in_ready", 64'(in_ready5), 64'd0);
         tick();
         check("n5_sel6_out_valid", 64'(out_valid5), 64'd0);
      end
      sel5 = 3'd4;
      #1;
      check("n5_sel4_in_ready", 64'(in_ready5), 64'h10);
      tick();
      check("n5_sel4_out_ch",   64'(out_ch5),   64'd4);
      check("n5_sel4_out_data", 64'(out_data5), 64'hB4);

      // Five-channel round-robin wraps 4 -> 0
      mode5 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("n5_rr_out_ch",   64'(out_ch5),   64'(rr5_seq[k]));
         check("n5_rr_out_data", 64'(out_data5), 64'(8'hB0 + 8'(rr5_seq[k])));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
